// File: rtl/bram_arbiter_if.sv
// Request/response bundle between the planner tree-store clients and the shared node RAM.
// Each per-port field is packed, with port i at slice i of its vector.
interface bram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_write_data;
  logic [NUM_PORTS-1:0]            req_write_enable;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]           resp_read_data;

  modport master (
    output req_valid, req_address, req_write_data, req_write_enable,
    input  req_ready, resp_valid, resp_read_data
  );

  modport slave (
    input  req_valid, req_address, req_write_data, req_write_enable,
    output req_ready, resp_valid, resp_read_data
  );
endinterface

// File: rtl/bram_arbiter.sv
// NUM_PORTS requesters sharing one read-first single-port RAM, one grant per cycle.
// Define BRAM_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration; default is round-robin.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4
) (
  input logic          clk,
  input logic          rst,
  bram_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NUM_PORTS-1:0]  grant;
  logic                  xfer;
  logic [PTR_W-1:0]      scanPtr;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic                  selWe;

  logic [NUM_PORTS-1:0]  respValid_q, respValid_d;
  logic [DATA_WIDTH-1:0] respData_q,  respData_d;

`ifndef BRAM_ARB_FIXED_PRIORITY_EN
  logic [PTR_W-1:0]      rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]      grantIdx;
`endif

  // First requester found scanning upward from the pointer wins; reset masks every grant.
  always_comb begin
    grant   = '0;
    xfer    = 1'b0;
    scanPtr = '0;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
    grantIdx = '0;
`endif
    for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
      scanPtr = PTR_W'(k);
`else
      scanPtr = PTR_W'((int'(rrPtr_q) + k) % NUM_PORTS);
`endif
      if (!xfer && bus.req_valid[scanPtr]) begin
        xfer           = 1'b1;
        grant[scanPtr] = 1'b1;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
        grantIdx       = scanPtr;
`endif
      end
    end
    if (rst) begin
      grant = '0;
      xfer  = 1'b0;
    end
  end

  always_comb begin
    selAddr  = '0;
    selWdata = '0;
    selWe    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        selAddr  = bus.req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        selWdata = bus.req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        selWe    = bus.req_write_enable[i];
      end
    end
  end

  // Response captures the pre-write word, so a write also returns the old contents.
  always_comb begin
    respValid_d = '0;
    respData_d  = respData_q;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
    rrPtr_d     = rrPtr_q;
`endif
    if (xfer) begin
      respValid_d = grant;
      respData_d  = mem[selAddr];
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
      rrPtr_d     = (grantIdx == PTR_W'(NUM_PORTS - 1)) ? '0 : grantIdx + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      respValid_q <= '0;
      respData_q  <= '0;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
      rrPtr_q     <= '0;
`endif
    end else begin
      respValid_q <= respValid_d;
      respData_q  <= respData_d;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
      rrPtr_q     <= rrPtr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && selWe) begin
      mem[selAddr] <= selWdata;
    end
  end

  assign bus.req_ready      = grant;
  assign bus.resp_valid     = respValid_q;
  assign bus.resp_read_data = respData_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized and directed checks of bram_arbiter against a shadow-memory model.
// The model picks the requester nearest at-or-after the last winner's successor.
module tb_bram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NP = 4;

  logic clk;
  logic rst;

  bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]  modelMem [int];
  int             modelPtr;
  logic [NP-1:0]  expValid;
  logic [DW-1:0]  expData;
  bit             dataKnown;
  logic [NP-1:0]  lastGrant;

  // Winner is the requesting port with the smallest forward distance from the pointer.
  function automatic logic [NP-1:0] modelGrant();
    logic [NP-1:0] g;
    int best;
    int bestDist;
    int base;
    g = '0;
    best = -1;
    bestDist = NP;
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
    base = 0;
`else
    base = modelPtr;
`endif
    for (int p = 0; p < NP; p++) begin
      if (bus.req_valid[p] && (((p - base + NP) % NP) < bestDist)) begin
        bestDist = (p - base + NP) % NP;
        best = p;
      end
    end
    if (best >= 0 && !rst) g[best] = 1'b1;
    return g;
  endfunction

  task automatic modelReset();
    modelPtr  = 0;
    expValid  = '0;
    expData   = '0;
    dataKnown = 1'b1;
  endtask

  task automatic clearReqs();
    bus.req_valid        = '0;
    bus.req_write_enable = '0;
    bus.req_address      = '0;
    bus.req_write_data   = '0;
  endtask

  task automatic drive(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[p]              = 1'b1;
    bus.req_write_enable[p]       = we;
    bus.req_address[p*AW +: AW]   = a;
    bus.req_write_data[p*DW +: DW] = d;
  endtask

  // Advance one rising edge and update the model from the inputs held across it.
  task automatic tick();
    logic [NP-1:0] g;
    int p;
    int a;
    g = modelGrant();
    lastGrant = g;
    @(posedge clk);
    if (g != '0) begin
      p = 0;
      for (int i = 0; i < NP; i++) if (g[i]) p = i;
      a = int'(bus.req_address[p*AW +: AW]);
      if (modelMem.exists(a)) begin
        expData   = modelMem[a];
        dataKnown = 1'b1;
      end else begin
        dataKnown = 1'b0;
      end
      if (bus.req_write_enable[p]) modelMem[a] = bus.req_write_data[p*DW +: DW];
      modelPtr = (p + 1) % NP;
      expValid = g;
    end else begin
      expValid = '0;
    end
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    clearReqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    modelReset();
    clearReqs();
    bus.req_valid = '1;
    #12;
    total++;
    if (bus.resp_valid !== 4'b0000) begin bad++; $display("[TB] FAIL reset_resp_valid: got %b expected 0000", bus.resp_valid); end
    total++;
    if (bus.resp_read_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_resp_data: got %h expected 0", bus.resp_read_data); end
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0000", bus.req_ready); end
    clearReqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(2, 1'b1, 10'h005, 32'hDEADBEEF);
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL write_ready: got %b expected 0100", bus.req_ready); end
    tick();
    total++;
    if (bus.resp_valid !== 4'b0100) begin bad++; $display("[TB] FAIL write_resp_valid: got %b expected 0100", bus.resp_valid); end
    @(negedge clk);
    clearReqs();
    drive(0, 1'b0, 10'h005, 32'h0);
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL read_ready: got %b expected 0001", bus.req_ready); end
    tick();
    total++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_read_data !== 32'hDEADBEEF)
      begin bad++; $display("[TB] FAIL read_resp: got %b/%h expected 0001/deadbeef", bus.resp_valid, bus.resp_read_data); end
    @(negedge clk);
    clearReqs();
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] want;
    doReset();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 10'h005, 32'h0);
    for (int c = 0; c < 8; c++) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
      want = 4'b0001;
`else
      want = 4'b0001 << (c % NP);
`endif
      #1;
      total++;
      if (bus.req_ready !== want) begin bad++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", c, bus.req_ready, want); end
      tick();
      total++;
      if (bus.resp_valid !== want || bus.resp_read_data !== 32'hDEADBEEF)
        begin bad++; $display("[TB] FAIL rr_resp%0d: got %b/%h expected %b/deadbeef", c, bus.resp_valid, bus.resp_read_data, want); end
      @(negedge clk);
    end
    clearReqs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1, 1'b1, 10'h00A, 32'h1);
    tick();
    total++;
    if (bus.resp_valid !== 4'b0010) begin bad++; $display("[TB] FAIL b2b_first_valid: got %b expected 0010", bus.resp_valid); end
    @(negedge clk);
    clearReqs();
    drive(3, 1'b1, 10'h00A, 32'h2);
    tick();
    total++;
    if (bus.resp_valid !== 4'b1000 || bus.resp_read_data !== 32'h1)
      begin bad++; $display("[TB] FAIL b2b_second_resp: got %b/%h expected 1000/00000001", bus.resp_valid, bus.resp_read_data); end
    @(negedge clk);
    clearReqs();
    drive(0, 1'b0, 10'h00A, 32'h0);
    tick();
    total++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_read_data !== 32'h2)
      begin bad++; $display("[TB] FAIL b2b_read_back: got %b/%h expected 0001/00000002", bus.resp_valid, bus.resp_read_data); end
    @(negedge clk);
    clearReqs();
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    drive(0, 1'b0, 10'h005, 32'h0);
    tick();
    total++;
    if (bus.resp_valid !== 4'b0001) begin bad++; $display("[TB] FAIL midop_pre_valid: got %b expected 0001", bus.resp_valid); end
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    total++;
    if (bus.resp_valid !== 4'b0000 || bus.resp_read_data !== 32'h0)
      begin bad++; $display("[TB] FAIL midop_async_drop: got %b/%h expected 0000/0", bus.resp_valid, bus.resp_read_data); end
    @(negedge clk);
    clearReqs();
    drive(2, 1'b1, 10'h005, 32'h55);
    #1;
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL midop_ready_in_reset: got %b expected 0000", bus.req_ready); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    clearReqs();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 10'h005, 32'h0);
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL midop_tie_after_reset: got %b expected 0001", bus.req_ready); end
    tick();
    total++;
    if (bus.resp_read_data !== 32'hDEADBEEF)
      begin bad++; $display("[TB] FAIL midop_write_blocked: got %h expected deadbeef", bus.resp_read_data); end
    @(negedge clk);
    clearReqs();
  endtask

  task automatic test_idle_gap();
    @(negedge clk);
    drive(1, 1'b0, 10'h00A, 32'h0);
    tick();
    total++;
    if (bus.resp_valid !== 4'b0010 || bus.resp_read_data !== 32'h2)
      begin bad++; $display("[TB] FAIL gap_first: got %b/%h expected 0010/00000002", bus.resp_valid, bus.resp_read_data); end
    @(negedge clk);
    clearReqs();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (bus.resp_valid !== 4'b0000 || bus.resp_read_data !== 32'h2)
        begin bad++; $display("[TB] FAIL gap_idle%0d: got %b/%h expected 0000/00000002", c, bus.resp_valid, bus.resp_read_data); end
    end
    @(negedge clk);
    drive(2, 1'b0, 10'h005, 32'h0);
    tick();
    total++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_read_data !== 32'hDEADBEEF)
      begin bad++; $display("[TB] FAIL gap_second: got %b/%h expected 0100/deadbeef", bus.resp_valid, bus.resp_read_data); end
    @(negedge clk);
    clearReqs();
    tick();
    total++;
    if (bus.resp_valid !== 4'b0000 || bus.resp_read_data !== 32'hDEADBEEF)
      begin bad++; $display("[TB] FAIL gap_after: got %b/%h expected 0000/deadbeef", bus.resp_valid, bus.resp_read_data); end
  endtask

  // Each port keeps a request pending until granted, then may issue a fresh one.
  task automatic test_random();
    @(negedge clk);
    clearReqs();
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!bus.req_valid[p] && ($urandom_range(0, 1) == 1))
          drive(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      end
      #1;
      total++;
      if (bus.req_ready !== modelGrant())
        begin bad++; $display("[TB] FAIL rand_ready%0d: got %b expected %b", c, bus.req_ready, modelGrant()); end
      tick();
      total++;
      if (bus.resp_valid !== expValid)
        begin bad++; $display("[TB] FAIL rand_valid%0d: got %b expected %b", c, bus.resp_valid, expValid); end
      if (dataKnown) begin
        total++;
        if (bus.resp_read_data !== expData)
          begin bad++; $display("[TB] FAIL rand_data%0d: got %h expected %h", c, bus.resp_read_data, expData); end
      end
      @(negedge clk);
      for (int p = 0; p < NP; p++) if (lastGrant[p]) bus.req_valid[p] = 1'b0;
    end
    clearReqs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_reset_midop();
    test_idle_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
